// File: rtl/sens_pkg.sv
// Shared types and defaults for the AND-change logger slice.
package sens_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    typedef enum logic {PRIME, RUN} state_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] prev;
        logic [DEF_WIDTH-1:0] curr;
    } evt_t;

endpackage

// File: rtl/and_change_logger_fifo.sv
// Show-ahead FIFO with occupancy count; storage resets to zero so the head never reads X.
module evt_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot the write pointer already aims at.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/and_change_logger.sv
// Samples a & b every clock and queues (previous, current) pairs on each sampled change.
module and_change_logger
    import sens_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic [WIDTH-1:0]       result,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [WIDTH-1:0]       evt_prev,
    output logic [WIDTH-1:0]       evt_curr,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             drop_count
);
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] last;
    logic             push_req;
    logic             pop;
    logic             full;
    logic             empty;
    logic [2*WIDTH-1:0] head;

    always_comb begin
        result = a & b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PRIME;
            last  <= '0;
        end else begin
            state <= state_nxt;
            last  <= result;
        end
    end

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        case (state)
            PRIME: state_nxt = RUN;
            RUN:   push_req  = (result != last);
            default: state_nxt = PRIME;
        endcase
    end

    assign evt_valid = !empty;
    assign pop       = evt_valid && evt_ready;

    evt_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   ({last, result}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign evt_prev = head[2*WIDTH-1:WIDTH];
    assign evt_curr = head[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (push_req && full && !pop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_and_change_logger.sv
// Randomized and directed check of and_change_logger against a queue-based event model.
module tb_and_change_logger;
    import sens_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic [7:0] result;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_prev, evt_curr;
    logic [2:0] level;
    logic [7:0] drop_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: sampled-value history plus a queue of pending events.
    evt_t        mq[$];
    logic [7:0]  m_last;
    bit          m_primed;
    int unsigned m_drops;

    and_change_logger #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .result     (result),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_prev   (evt_prev),
        .evt_curr   (evt_curr),
        .level      (level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_last   = '0;
        m_primed = 0;
        m_drops  = 0;
    endfunction

    // Applies one clock edge's worth of behaviour using the pre-edge inputs.
    function automatic void model_edge(input logic [7:0] res, input logic rdy);
        evt_t e;
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (m_primed && res != m_last) begin
            if (mq.size() < DEPTH) begin
                e.prev = m_last;
                e.curr = res;
                mq.push_back(e);
            end else if (m_drops < 255) begin
                m_drops++;
            end
        end
        m_last   = res;
        m_primed = 1;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".result"}, 32'(result), 32'(a & b));
        check({tag, ".valid"},  32'(evt_valid), 32'(mq.size() != 0));
        check({tag, ".level"},  32'(level), mq.size());
        check({tag, ".drops"},  32'(drop_count), m_drops);
        if (mq.size() != 0) begin
            check({tag, ".prev"}, 32'(evt_prev), 32'(mq[0].prev));
            check({tag, ".curr"}, 32'(evt_curr), 32'(mq[0].curr));
        end
    endtask

    // Inputs change right after a negedge; outputs are compared at the next negedge.
    task automatic cycle(input logic [7:0] na, input logic [7:0] nb, input logic r, input string tag);
        logic [7:0] res;
        a = na; b = nb; evt_ready = r;
        @(posedge clk);
        res = a & b;
        model_edge(res, evt_ready);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, ".rst_valid"}, 32'(evt_valid), 0);
        check({tag, ".rst_level"}, 32'(level), 0);
        check({tag, ".rst_drops"}, 32'(drop_count), 0);
        check({tag, ".rst_prev"},  32'(evt_prev), 0);
        check({tag, ".rst_curr"},  32'(evt_curr), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] res;
        rst = 1'b1; a = 8'hFF; b = 8'h0F; evt_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset.valid", 32'(evt_valid), 0);
        check("reset.level", 32'(level), 0);
        check("reset.drops", 32'(drop_count), 0);
        check("reset.prev",  32'(evt_prev), 0);
        check("reset.curr",  32'(evt_curr), 0);
        check("reset.result", 32'(result), 32'h0F);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) cycle(8'hFF, 8'h0F, 1'b0, "prime");
        check("prime.level0", 32'(level), 0);

        cycle(8'hFF, 8'hF0, 1'b0, "first_evt");
        check("first_evt.prev", 32'(evt_prev), 32'h0F);
        check("first_evt.curr", 32'(evt_curr), 32'hF0);
        cycle(8'hFF, 8'hF0, 1'b1, "drain1");
        check("drain1.valid", 32'(evt_valid), 0);

        cycle(8'hFF, 8'h0F, 1'b0, "back0f");
        cycle(8'hFF, 8'h0F, 1'b1, "drain2");
        for (int i = 0; i < 6; i++) cycle(8'hFF, 8'(1 << i), 1'b0, "fill");
        check("fill.level4", 32'(level), 4);
        check("fill.drops2", 32'(drop_count), 2);
        check("fill.head_prev", 32'(evt_prev), 32'h0F);
        check("fill.head_curr", 32'(evt_curr), 32'h01);

        cycle(8'hFF, 8'h40, 1'b1, "full_push_pop");
        check("full_push_pop.level", 32'(level), 4);
        check("full_push_pop.drops", 32'(drop_count), 2);
        check("full_push_pop.head_prev", 32'(evt_prev), 32'h01);

        for (int i = 0; i < 300; i++) cycle(8'hFF, (i % 2) ? 8'h55 : 8'hAA, 1'b0, "ovf");
        check("ovf.sat255", 32'(drop_count), 255);

        for (int i = 0; i < 4; i++) cycle(8'hFF, 8'hF0, 1'b1, "drain3");
        cycle(8'hFF, 8'hF0, 1'b1, "settle");
        check("settle.empty", 32'(evt_valid), 0);

        // Glitch between edges: sampled value unchanged, so no event.
        a = 8'hFF; b = 8'h0F; evt_ready = 1'b0;
        #2 b = 8'hF0;
        @(posedge clk);
        res = a & b;
        model_edge(res, evt_ready);
        @(negedge clk);
        compare_all("glitch");
        check("glitch.no_evt", 32'(evt_valid), 0);

        cycle(8'hFF, 8'h11, 1'b0, "pre3");
        cycle(8'hFF, 8'h22, 1'b0, "pre3");
        cycle(8'hFF, 8'h33, 1'b0, "pre3");
        check("pre3.level", 32'(level), 3);
        async_reset("mid");
        cycle(8'hFF, 8'h44, 1'b0, "post_prime");
        check("post_prime.none", 32'(evt_valid), 0);
        cycle(8'hFF, 8'h55, 1'b0, "post_evt");
        check("post_evt.level1", 32'(level), 1);

        for (int i = 0; i < 500; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 3)) | 8'hF0;
            rb = ($urandom_range(0, 2) == 0) ? b : 8'($urandom);
            cycle(ra, rb, 1'($urandom_range(0, 2) == 0), "rand");
            if ($urandom_range(0, 79) == 0) async_reset("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
